// File: rtl/covert_pkg.sv
// rtl/covert_pkg.sv - shared state encoding and LED bit positions for the covert string checker
package covert_pkg;

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  localparam int LED_DONE = 7;
  localparam int LED_TMO  = 6;
  localparam int LED_PASS = 5;
  localparam int LED_BUSY = 4;

endpackage

// File: rtl/pb_debounce.sv
// rtl/pb_debounce.sv - pushbutton synchroniser, debounce and single press pulse
module pb_debounce #(
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          pb_s1;
  logic          pb_s2;
  logic          armed;
  logic [CW-1:0] cnt;

  // armed drops after a press and only returns once the button is seen low,
  // so a long hold yields a single event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_s1 <= 1'b0;
      pb_s2 <= 1'b0;
      armed <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      pb_s1 <= pb;
      pb_s2 <= pb_s1;
      press <= 1'b0;
      if (!pb_s2) begin
        cnt   <= '0;
        armed <= 1'b1;
      end else if (armed) begin
        if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
          press <= 1'b1;
          armed <= 1'b0;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/covert_string_checker.sv
// rtl/covert_string_checker.sv - compares received covert bits against a latched repeating test string
module covert_string_checker
  import covert_pkg::*;
#(
  parameter int STR_W        = 4,
  parameter int NUM_ROUNDS   = 16,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int TIMEOUT_CYC  = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PB1,
  input  logic [STR_W-1:0] Y,
  input  logic             rx_valid,
  input  logic             rx_bit,
  output logic             start_tx,
  output logic [7:0]       led
);

  localparam int TOTAL = NUM_ROUNDS * STR_W;
  localparam int BW    = $clog2(TOTAL + 1);
  localparam int IW    = $clog2(TIMEOUT_CYC + 1);
  localparam int XW    = (STR_W > 1) ? $clog2(STR_W) : 1;

  state_t           state;
  state_t           state_n;
  logic             press;
  logic [STR_W-1:0] exp_reg;
  logic [XW-1:0]    bit_idx;
  logic [XW-1:0]    sel;
  logic [BW-1:0]    bit_cnt;
  logic [IW-1:0]    idle_cnt;
  logic [3:0]       err_cnt;
  logic [3:0]       err_next;
  logic             done_r;
  logic             tmo_r;
  logic             pass_r;
  logic             busy_r;
  logic             last_bit;
  logic             idle_exp;

  pb_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_pb (
    .clk  (clk),
    .rst_n(rst_n),
    .pb   (PB1),
    .press(press)
  );

  // string is sent MSB first, so bit_idx counts down from the top of exp_reg
  assign sel      = XW'(STR_W - 1) - bit_idx;
  assign err_next = ((rx_bit != exp_reg[sel]) && (err_cnt != 4'hF)) ? err_cnt + 4'd1 : err_cnt;
  assign last_bit = (bit_cnt == BW'(TOTAL - 1));
  assign idle_exp = (idle_cnt == IW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (press) state_n = RECV;
      RECV: begin
        if (rx_valid && last_bit)       state_n = DONE;
        else if (!rx_valid && idle_exp) state_n = DONE;
      end
      DONE:    if (press) state_n = RECV;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_reg  <= '0;
      bit_idx  <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
      err_cnt  <= '0;
      done_r   <= 1'b0;
      tmo_r    <= 1'b0;
      pass_r   <= 1'b0;
      busy_r   <= 1'b0;
      start_tx <= 1'b0;
    end else begin
      start_tx <= 1'b0;
      busy_r   <= (state_n == RECV);
      case (state)
        IDLE, DONE: begin
          if (press) begin
            exp_reg  <= Y;
            bit_idx  <= '0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
            err_cnt  <= '0;
            done_r   <= 1'b0;
            tmo_r    <= 1'b0;
            pass_r   <= 1'b0;
            start_tx <= 1'b1;
          end
        end
        RECV: begin
          if (rx_valid) begin
            err_cnt  <= err_next;
            bit_idx  <= (bit_idx == XW'(STR_W - 1)) ? '0 : bit_idx + 1'b1;
            idle_cnt <= '0;
            if (bit_cnt != BW'(TOTAL)) bit_cnt <= bit_cnt + 1'b1;
            if (last_bit) begin
              done_r <= 1'b1;
              pass_r <= (err_next == 4'd0);
            end
          end else begin
            if (idle_cnt != IW'(TIMEOUT_CYC)) idle_cnt <= idle_cnt + 1'b1;
            if (idle_exp) begin
              done_r <= 1'b1;
              tmo_r  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign led[LED_DONE] = done_r;
  assign led[LED_TMO]  = tmo_r;
  assign led[LED_PASS] = pass_r;
  assign led[LED_BUSY] = busy_r;
  assign led[3:0]      = err_cnt;

endmodule

// File: tb/tb_covert_string_checker.sv
// tb/tb_covert_string_checker.sv - randomized and directed self-checking bench for covert_string_checker
module tb_covert_string_checker;

  typedef bit bitq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       PB1 = 1'b0;
  logic [3:0] Y = 4'h0;
  logic       rx_valid = 1'b0;
  logic       rx_bit = 1'b0;
  logic       start_tx;
  logic [7:0] led;

  int checks = 0;
  int errors = 0;
  int starts = 0;

  covert_string_checker #(
    .STR_W(4), .NUM_ROUNDS(16), .DEBOUNCE_CYC(1000), .TIMEOUT_CYC(65535)
  ) dut (
    .clk(clk), .rst_n(rst_n), .PB1(PB1), .Y(Y),
    .rx_valid(rx_valid), .rx_bit(rx_bit), .start_tx(start_tx), .led(led)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start_tx === 1'b1) starts++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // string repeated MSB first, 64 bits total
  function automatic bitq_t ideal(input logic [3:0] y);
    bitq_t q;
    for (int i = 0; i < 64; i++) q.push_back(y[3 - (i % 4)]);
    return q;
  endfunction

  function automatic int count_err(input logic [3:0] y, input bitq_t q);
    int e = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] != y[3 - (i % 4)]) e++;
    return (e > 15) ? 15 : e;
  endfunction

  function automatic logic [7:0] model_done(input logic [3:0] y, input bitq_t q);
    int e = count_err(y, q);
    return {1'b1, 1'b0, (e == 0), 1'b0, 4'(e)};
  endfunction

  task automatic press(input string tag, input int hold);
    int s0 = starts;
    PB1 = 1'b1;
    tick(hold);
    PB1 = 1'b0;
    tick(4);
    check({tag, "_start_pulses"}, starts - s0, 1);
    check({tag, "_busy_after_press"}, led, 8'h10);
  endtask

  task automatic send(input bitq_t q, input int from, input int to, input bit wiggle_y);
    for (int i = from; i < to; i++) begin
      rx_valid = 1'b1;
      rx_bit   = q[i];
      if (wiggle_y) Y = 4'($urandom);
      tick(1);
      rx_valid = 1'b0;
      tick(2);
    end
  endtask

  initial begin
    bitq_t q;
    logic [3:0] y;
    logic [7:0] held;
    int bad;
    int s0;
    int waited;

    // reset held with activity on the inputs
    PB1 = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      rx_valid = ~rx_valid;
      rx_bit   = 1'($urandom);
      tick(1);
      if (led !== 8'h00 || start_tx !== 1'b0) bad++;
    end
    check("reset_hold_bad_cycles", bad, 0);
    check("reset_led", led, 8'h00);
    PB1 = 1'b0;
    rx_valid = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    send(ideal(4'hA), 0, 5, 1'b0);
    check("idle_ignores_rx", led, 8'h00);
    check("idle_no_start", starts, 0);

    // clean 1010 stream
    Y = 4'b1010;
    press("s2", 1200);
    q = ideal(4'b1010);
    send(q, 0, 64, 1'b0);
    tick(3);
    check("s2_clean_led", led, 8'hA0);
    check("s2_model", led, model_done(4'b1010, q));

    // bits 3 and 6 flipped
    press("s3a", 1050);
    q = ideal(4'b1010);
    q[3] = ~q[3];
    q[6] = ~q[6];
    send(q, 0, 64, 1'b0);
    tick(3);
    check("s3_two_errors", led, 8'h82);

    // every bit inverted saturates the error count
    press("s3b", 1050);
    q = ideal(4'b1010);
    for (int i = 0; i < 64; i++) q[i] = ~q[i];
    send(q, 0, 64, 1'b0);
    tick(3);
    check("s3_saturate", led, 8'h8F);

    // press during RECV is ignored and the stream continues
    y = 4'($urandom);
    Y = y;
    press("rp", 1050);
    q = ideal(y);
    q[2] = ~q[2];
    q[40] = ~q[40];
    send(q, 0, 20, 1'b1);
    s0 = starts;
    PB1 = 1'b1;
    tick(1100);
    PB1 = 1'b0;
    tick(4);
    check("rp_no_restart", starts - s0, 0);
    check("rp_still_busy", led, 8'h11);
    send(q, 20, 64, 1'b1);
    tick(3);
    check("rp_result", led, model_done(y, q));

    // randomized strings and error patterns, Y changing after the latch
    for (int r = 0; r < 2; r++) begin
      y = 4'($urandom);
      Y = y;
      press("rnd", 1050);
      q = ideal(y);
      for (int i = 0; i < 64; i++) if ($urandom_range(0, 9) == 0) q[i] = ~q[i];
      send(q, 0, 64, 1'b1);
      tick(3);
      check("rnd_result", led, model_done(y, q));
    end

    // timeout after 10 bits
    y = 4'($urandom);
    Y = y;
    press("s4", 1050);
    q = ideal(y);
    q[5] = ~q[5];
    send(q, 0, 10, 1'b0);
    waited = 0;
    while (led[7] !== 1'b1 && waited < 66000) begin
      tick(1);
      waited++;
    end
    check("s4_timeout_window", (waited >= 65528 && waited <= 65540), 1);
    check("s4_flags", led[7:4], 4'hC);
    check("s4_err", led[3:0], 4'(count_err(y, q[0:9])));
    held = led;
    send(q, 10, 15, 1'b0);
    check("s4_rx_ignored", led, held);

    // glitch and bounce never produce a press
    s0 = starts;
    held = led;
    PB1 = 1'b1;
    tick(500);
    PB1 = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      PB1 = 1'b1;
      tick($urandom_range(1, 900));
      PB1 = 1'b0;
      tick($urandom_range(1, 5));
    end
    tick(5);
    check("s5_no_start", starts - s0, 0);
    check("s5_led_held", led, held);

    // asynchronous reset in the middle of a stream
    y = 4'($urandom);
    Y = y;
    press("s6", 1050);
    q = ideal(y);
    q[1] = ~q[1];
    send(q, 0, 20, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("s6_led_cleared_async", led, 8'h00);
    check("s6_start_low", start_tx, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("s6_idle_after_reset", led, 8'h00);
    Y = y;
    press("s6b", 1050);
    q = ideal(y);
    send(q, 0, 64, 1'b0);
    tick(3);
    check("s6_clean_pass", led, 8'hA0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
